// File: rtl/note_scheduler_pkg.sv
// note_scheduler_pkg: shared FSM encoding and sizing constants for the note scheduler.
package note_scheduler_pkg;
    localparam int NUM_LANES_DEF = 6;
    localparam int TICK_W = 16;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_LATCH     = 3'd2;
    localparam logic [2:0] S_DISPATCH  = 3'd3;
    localparam logic [2:0] S_WAIT_TICK = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    function automatic int ptr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/note_scheduler_arb.sv
// rr_lane_arbiter: grants the first pending lane at or after rr_ptr, wrapping around.
module rr_lane_arbiter import note_scheduler_pkg::*; #(
    parameter int NUM_LANES = NUM_LANES_DEF
) (
    input  logic [NUM_LANES-1:0]          pending,
    input  logic [ptr_w(NUM_LANES)-1:0]   rr_ptr,
    output logic [NUM_LANES-1:0]          grant
);
    // walk from farthest to nearest so the nearest pending lane wins
    always_comb begin
        grant = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--)
            if (pending[(int'(rr_ptr) + k) % NUM_LANES]) begin
                grant = '0;
                grant[(int'(rr_ptr) + k) % NUM_LANES] = 1'b1;
            end
    end
endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: steps through a song pattern ROM and issues one lane strobe per cycle each step.
module note_scheduler import note_scheduler_pkg::*; #(
    parameter int                NUM_LANES = NUM_LANES_DEF,
    parameter logic [TICK_W-1:0] TICK_DIV  = 16'd50000,
    parameter logic [7:0]        SONG_LEN  = 8'd200
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 pause,
    output logic [7:0]           pat_addr,
    input  logic [NUM_LANES-1:0] pat_data,
    output logic [NUM_LANES-1:0] map,
    output logic [7:0]           step_cnt,
    output logic                 busy,
    output logic                 done
);
    localparam int PW = ptr_w(NUM_LANES);
    logic [2:0]           state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [NUM_LANES-1:0] pending, grant, left;
    logic [PW-1:0]        rr_ptr, rr_next;
    logic [7:0]           adv_step;
    logic [2:0]           adv_state;
    logic                 tick, last_step;

    rr_lane_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
        .pending(pending),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
    assign tick      = busy && !pause && tick_cnt == TICK_DIV - 1'b1;
    assign left      = pending & ~grant;
    assign last_step = step_cnt == SONG_LEN - 8'd1;
    assign adv_step  = last_step ? step_cnt : step_cnt + 8'd1;
    assign adv_state = last_step ? S_DONE : S_FETCH;
    assign rr_next   = rr_ptr == PW'(NUM_LANES - 1) ? '0 : rr_ptr + 1'b1;

    // a tick landing on the final grant advances directly, keeping the step period exact
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            pending  <= '0;
            rr_ptr   <= '0;
            map      <= '0;
            step_cnt <= '0;
            pat_addr <= '0;
        end else begin
            map <= '0;
            if (busy && !pause)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_FETCH;
                    step_cnt <= '0;
                    pat_addr <= '0;
                    tick_cnt <= '0;
                end
                S_FETCH: begin
                    pat_addr <= step_cnt;
                    state    <= S_LATCH;
                end
                S_LATCH: begin
                    pending <= pat_data;
                    state   <= |pat_data ? S_DISPATCH : S_WAIT_TICK;
                end
                S_DISPATCH: begin
                    map     <= grant;
                    pending <= left;
                    if (left == '0) begin
                        rr_ptr   <= rr_next;
                        state    <= tick ? adv_state : S_WAIT_TICK;
                        step_cnt <= tick ? adv_step : step_cnt;
                        pat_addr <= tick ? adv_step : pat_addr;
                    end
                end
                S_WAIT_TICK: if (tick) begin
                    state    <= adv_state;
                    step_cnt <= adv_step;
                    pat_addr <= adv_step;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: random songs checked against a step-timing and lane-order reference model.
module tb_note_scheduler;
    logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, pause = 1'b0;
    logic [7:0] pat_addr, step_cnt;
    logic [5:0] pat_data = '0, map;
    logic       busy, done;
    logic [5:0] rom [0:255];
    int         n_chk = 0, n_pass = 0, cyc = 0, rr = 0;
    bit         pause_log [0:8191];
    int         got_map_cyc[$], got_map_lane[$], got_start_cyc[$], got_start_step[$], got_done[$], got_fall[$];
    logic       busy_q = 1'b0;
    logic [7:0] step_q = '0;

    note_scheduler #(.NUM_LANES(6), .TICK_DIV(16'd8), .SONG_LEN(8'd3)) dut (
        .clk(clk), .resetn(resetn), .start(start), .pause(pause),
        .pat_addr(pat_addr), .pat_data(pat_data), .map(map),
        .step_cnt(step_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pat_data <= rom[pat_addr];
    always @(posedge clk) begin
        if (cyc < 8192) pause_log[cyc] = pause;
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic reset_checks();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_map", int'(map), 0);
        check("rst_step_cnt", int'(step_cnt), 0);
        check("rst_pat_addr", int'(pat_addr), 0);
    endtask

    always @(negedge clk) begin
        if (map != '0) begin
            check("map_onehot", $countones(map), 1);
            got_map_cyc.push_back(cyc);
            got_map_lane.push_back($clog2(map));
        end
        if (busy && (!busy_q || step_cnt != step_q)) begin
            got_start_cyc.push_back(cyc);
            got_start_step.push_back(int'(step_cnt));
        end
        if (!busy && busy_q) got_fall.push_back(cyc);
        if (done) got_done.push_back(cyc);
        busy_q = busy;
        step_q = step_cnt;
    end

    // pa/pl: pause window, sm: stray start offset, ro: reset offset (-1 = none), all relative to step 0
    task automatic run_song(input logic [5:0] p0, p1, p2, input int pa, pl, sm, ro);
        int s, c, n, i, lane, n_st;
        int st[4];
        int e_cyc[$], e_lane[$];
        logic [5:0] m;
        rom[0] = p0; rom[1] = p1; rom[2] = p2;
        got_map_cyc.delete(); got_map_lane.delete(); got_start_cyc.delete();
        got_start_step.delete(); got_done.delete(); got_fall.delete();
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            start = (t == sm);
            pause = t >= pa && t < pa + pl;
            if (t == ro) resetn = 1'b0;
            if (ro >= 0 && t == ro + 1) reset_checks();
            if (ro >= 0 && t == ro + 2) resetn = 1'b1;
            if (ro >= 0 ? t >= ro + 30 : (got_done.size() > 0 && cyc > got_done[0] + 2)) break;
        end
        pause = 1'b0;
        start = 1'b0;
        st[0] = s;
        for (int k = 0; k < 3; k++) begin
            c = st[k];
            n = 0;
            while (c < 8190) begin
                if (!pause_log[c]) n++;
                if (n == 8) break;
                c++;
            end
            st[k + 1] = c + 1;
        end
        for (int k = 0; k < 3; k++) begin
            m = k == 0 ? p0 : k == 1 ? p1 : p2;
            i = 0;
            for (int j = 0; j < 6; j++) begin
                lane = (rr + j) % 6;
                if (m[lane]) begin
                    if (ro < 0 || st[k] + 3 + i <= s + ro) begin
                        e_cyc.push_back(st[k] + 3 + i);
                        e_lane.push_back(lane);
                    end
                    i++;
                end
            end
            if (m != '0) rr = (rr + 1) % 6;
        end
        if (ro >= 0) rr = 0;
        check("map_count", got_map_cyc.size(), e_cyc.size());
        for (int q = 0; q < e_cyc.size() && q < got_map_cyc.size(); q++) begin
            check("map_cycle", got_map_cyc[q] - s, e_cyc[q] - s);
            check("map_lane", got_map_lane[q], e_lane[q]);
        end
        n_st = 0;
        for (int k = 0; k < 3; k++) if (ro < 0 || st[k] <= s + ro) n_st++;
        check("start_count", got_start_cyc.size(), n_st);
        for (int k = 0; k < n_st && k < got_start_cyc.size(); k++) begin
            check("start_cycle", got_start_cyc[k] - s, st[k] - s);
            check("start_step", got_start_step[k], k);
        end
        check("done_count", got_done.size(), ro < 0 ? 1 : 0);
        if (ro < 0 && got_done.size() > 0) check("done_cycle", got_done[0] - s, st[3] - s);
        check("fall_count", got_fall.size(), 1);
        check("busy_fall", got_fall.size() > 0 ? got_fall[0] - s : -1, ro < 0 ? st[3] + 1 - s : ro + 1);
    endtask

    initial begin
        int pa, pl, sm, ro;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        reset_checks();
        resetn = 1'b1;
        run_song(6'b000001, 6'b000000, 6'b100000, 0, 0, -1, -1);
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks();
        resetn = 1'b1;
        rr = 0;
        run_song(6'b111111, 6'b111111, 6'b111111, 0, 0, -1, -1);
        run_song(6'b000001, 6'b000010, 6'b000100, 4, 20, -1, -1);
        run_song(6'b111111, 6'b111111, 6'b111111, 0, 0, -1, 10);
        run_song(6'b101010, 6'b010101, 6'b110011, 0, 0, 12, -1);
        repeat (20) begin
            pa = $urandom_range(0, 20);
            pl = $urandom_range(0, 1) != 0 ? $urandom_range(1, 15) : 0;
            ro = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : -1;
            sm = (ro < 0 && $urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : -1;
            run_song(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), pa, pl, sm, ro);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
